// File: rtl/fwd_scoreboard.sv
`default_nettype none
// fwd_scoreboard: D-stage hazard/forwarding scoreboard with a HI/LO busy counter. Rev 1.0
// Optional macro FWD_STALL_CNT_EN adds a saturating stall-cycle counter port (stall_cnt).
module fwd_scoreboard #(
  parameter int NSTAGE  = 3,
  parameter int NSRC    = 2,
  parameter int TW      = 2,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              pipe_en,
  input  logic                              d_valid,
  input  logic                              d_wen,
  input  logic [4:0]                        d_rd,
  input  logic [TW-1:0]                     d_tnew,
  input  logic [NSRC*5-1:0]                 d_src,
  input  logic [NSRC*TW-1:0]                d_tuse,
  input  logic [NSRC-1:0]                   d_src_use,
  input  logic                              d_md_start,
  input  logic                              d_md_div,
  input  logic                              d_md_use,
  output logic                              stall,
  output logic [NSRC*$clog2(NSTAGE+1)-1:0]  fwd_sel,
  output logic                              md_busy
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0]                       stall_cnt
`endif
);

  localparam int SW  = $clog2(NSTAGE + 1);
  localparam int MDW = $clog2(DIV_LAT + 1);

  // Entry index 0 holds stage E (stage number 1).
  logic [NSTAGE-1:0] ent_valid;
  logic [4:0]        ent_rd   [NSTAGE];
  logic [TW-1:0]     ent_tnew [NSTAGE];
  logic [MDW-1:0]    md_cnt;

  logic [NSRC-1:0]   op_hit;
  logic [NSRC-1:0]   op_stall;
  logic [SW-1:0]     hit_stage [NSRC];
  logic [TW-1:0]     hit_tnew  [NSRC];
  logic              md_accept;

  // Scan oldest to youngest so the youngest visible match is the one that sticks.
  always_comb begin
    op_hit   = '0;
    op_stall = '0;
    fwd_sel  = '0;
    for (int i = 0; i < NSRC; i++) begin
      hit_stage[i] = '0;
      hit_tnew[i]  = '0;
      for (int k = NSTAGE - 1; k >= 0; k--) begin
        if (ent_valid[k] && (ent_rd[k] != 5'd0) && (ent_rd[k] == d_src[5*i +: 5])) begin
          op_hit[i]    = 1'b1;
          hit_stage[i] = SW'(k + 1);
          hit_tnew[i]  = ent_tnew[k];
        end
      end
      if (d_src_use[i] && op_hit[i]) begin
        if (hit_tnew[i] > d_tuse[TW*i +: TW]) begin
          op_stall[i] = 1'b1;
        end else if (hit_tnew[i] == '0) begin
          fwd_sel[SW*i +: SW] = hit_stage[i];
        end
      end
    end
  end

  assign md_busy   = (md_cnt != '0);
  assign stall     = d_valid & ((|op_stall) | (d_md_use & md_busy));
  assign md_accept = pipe_en & d_valid & d_md_start & ~stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent_valid <= '0;
      for (int k = 0; k < NSTAGE; k++) begin
        ent_rd[k]   <= '0;
        ent_tnew[k] <= '0;
      end
    end else if (pipe_en) begin
      ent_valid[0] <= d_valid & d_wen & ~stall;
      ent_rd[0]    <= d_rd;
      ent_tnew[0]  <= d_tnew;
      for (int k = 1; k < NSTAGE; k++) begin
        ent_valid[k] <= ent_valid[k-1];
        ent_rd[k]    <= ent_rd[k-1];
        ent_tnew[k]  <= (ent_tnew[k-1] == '0) ? '0 : ent_tnew[k-1] - TW'(1);
      end
    end
  end

  // Counter runs independently of pipe_en so a frozen pipeline cannot extend the wait.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_cnt <= '0;
    end else if (md_accept) begin
      md_cnt <= d_md_div ? MDW'(DIV_LAT) : MDW'(MUL_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - MDW'(1);
    end
  end

`ifdef FWD_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (stall && pipe_en && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire
